// File: rtl/aes_job_arbiter_if.sv
// Handshake bundle between the job requesters / AES core and the job arbiter.
// master: environment side (requesters and core); slave: the arbiter itself.
interface aes_job_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned REQ_IDX_W = 2
);

  // Requester side
  logic [NUM_REQ-1:0]   req_valid;
  logic [2*NUM_REQ-1:0] req_mode;
  logic [NUM_REQ-1:0]   req_enc_dec;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [1:0]           rsp_status;

  // Core side
  logic                 core_start;
  logic [1:0]           core_mode;
  logic                 core_enc_dec;
  logic [3:0]           core_round_amount;
  logic [REQ_IDX_W-1:0] core_sel;
  logic                 core_done;
  logic                 core_flush;
  logic                 busy;

  modport master (
    output req_valid, req_mode, req_enc_dec, core_done,
    input  req_ready, rsp_valid, rsp_status, core_start, core_mode, core_enc_dec,
           core_round_amount, core_sel, core_flush, busy
  );

  modport slave (
    input  req_valid, req_mode, req_enc_dec, core_done,
    output req_ready, rsp_valid, rsp_status, core_start, core_mode, core_enc_dec,
           core_round_amount, core_sel, core_flush, busy
  );

endinterface

// File: rtl/aes_job_arbiter.sv
// Round-robin job arbiter sharing one AES round FSM/datapath among NUM_REQ requesters.
// Flow per job: IDLE -> GRANT -> LAUNCH -> BUSY -> RESP (illegal mode skips the core).
// Optional BUSY watchdog with core flush is enabled by defining AES_ARB_TIMEOUT_EN.
module aes_job_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned REQ_IDX_W      = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             reset,
  aes_job_arbiter_if.slave bus
);

  // Elaboration-time parameter sanity checks
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (REQ_IDX_W != $clog2(NUM_REQ)) begin : g_bad_idx_w
    $error("REQ_IDX_W must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit watchdog counter");
  end

  typedef enum logic [2:0] {
    StIdle,
    StGrant,
    StLaunch,
    StBusy,
    StResp
  } state_e;

  localparam logic [1:0] StatusOk      = 2'b00;
  localparam logic [1:0] StatusBadMode = 2'b01;
  localparam logic [1:0] StatusTimeout = 2'b10;

  state_e               state_q, state_d;
  logic [REQ_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [REQ_IDX_W-1:0] sel_q, sel_d;
  logic [1:0]           mode_q, mode_d;
  logic                 enc_dec_q, enc_dec_d;
  logic [3:0]           round_q, round_d;
  logic [1:0]           status_q, status_d;

  logic                 grant_found;
  logic [REQ_IDX_W-1:0] grant_idx;
  logic [REQ_IDX_W-1:0] cand;
  logic [1:0]           grant_mode;
  logic                 tmo_hit;

`ifdef AES_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // Counter value is the number of BUSY cycles already elapsed before this one
  assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog next-state: cleared while launching, counts every BUSY cycle
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StLaunch) begin
      tmo_cnt_d = '0;
    end else if (state_q == StBusy) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Round-robin search: first valid requester starting at rr_ptr, wrapping mod NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = REQ_IDX_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_mode = bus.req_mode[{grant_idx, 1'b0} +: 2];
  end

  // Next-state logic and latching of the granted job's fields
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    sel_d     = sel_q;
    mode_d    = mode_q;
    enc_dec_d = enc_dec_q;
    round_d   = round_q;
    status_d  = status_q;

    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          sel_d     = grant_idx;
          mode_d    = grant_mode;
          enc_dec_d = bus.req_enc_dec[grant_idx];
          rr_ptr_d  = (grant_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          unique case (grant_mode)
            2'b00:   round_d = 4'd10;
            2'b01:   round_d = 4'd12;
            2'b10:   round_d = 4'd14;
            default: round_d = 4'd0;
          endcase
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (mode_q == 2'b11) begin
          status_d = StatusBadMode;
          state_d  = StResp;
        end else begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        state_d = StBusy;
      end
      StBusy: begin
        // Done beats the watchdog when both land in the same cycle
        if (bus.core_done) begin
          status_d = StatusOk;
          state_d  = StResp;
        end else if (tmo_hit) begin
          status_d = StatusTimeout;
          state_d  = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and latched-job registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      sel_q     <= '0;
      mode_q    <= '0;
      enc_dec_q <= 1'b0;
      round_q   <= '0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
      enc_dec_q <= enc_dec_d;
      round_q   <= round_d;
      status_q  <= status_d;
    end
  end

  // Output decode from the registered state
  always_comb begin
    bus.req_ready  = '0;
    bus.rsp_valid  = '0;
    bus.rsp_status = 2'b00;
    bus.core_start = 1'b0;
    bus.core_flush = 1'b0;
    bus.busy       = (state_q != StIdle);
    if (state_q == StGrant) begin
      bus.req_ready[sel_q] = 1'b1;
    end
    if (state_q == StLaunch) begin
      bus.core_start = 1'b1;
    end
    if (state_q == StBusy && tmo_hit && !bus.core_done) begin
      bus.core_flush = 1'b1;
    end
    if (state_q == StResp) begin
      bus.rsp_valid[sel_q] = 1'b1;
      bus.rsp_status       = status_q;
    end
  end

  assign bus.core_mode         = mode_q;
  assign bus.core_enc_dec      = enc_dec_q;
  assign bus.core_round_amount = round_q;
  assign bus.core_sel          = sel_q;

endmodule
